csa_result_accum: RTL and testbench

- Downstream stage of the 8-bit three-operand carry-save adder.
- Consumes the adder's registered result {carry, sum[7:0]} as a 9-bit word per beat and accumulates a burst of beats into a wider running total.
- Presents the final total, beat count and overflow flag on a valid/ready output handshake.
- Upstream control asserts in_valid aligned with the adder's registered output, i.e. one clock after operands are applied.

---
 rtl/csa_pkg.sv | 17 +
 rtl/csa_accum_reg.sv | 60 ++++++
 rtl/csa_result_accum.sv | 152 +++++++++++++++
 tb/tb_csa_result_accum.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save adder result path.
// Holds the result-accumulator FSM state encoding and the word widths
// produced by the upstream 8-bit three-operand carry-save adder.
package csa_pkg;

    // Result accumulator control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Adder operand width and width of its registered {carry, sum} result
    localparam int ADD_W  = 8;
    localparam int WORD_W = ADD_W + 1;

endpackage

// File: rtl/csa_accum_reg.sv
// Running-total register bank for a burst of adder result words.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear         drop the running total, count and overflow flag
//   load_first    start a burst: acc=w, cnt=1, ovf=0
//   add           add w into the running total
//   w             9-bit adder result word {carry, sum}
//   acc/cnt/ovf   current running total, beat count, sticky wrap flag
//   acc_next/cnt_next/ovf_next  values after adding w, so the top can
//                 capture the final beat directly into its result registers
module csa_accum_reg
    import csa_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_first,
    input  logic              add,
    input  logic [WORD_W-1:0] w,
    output logic [ACC_W-1:0]  acc,
    output logic [CNT_W-1:0]  cnt,
    output logic              ovf,
    output logic [ACC_W-1:0]  acc_next,
    output logic [CNT_W-1:0]  cnt_next,
    output logic              ovf_next
);

    logic [ACC_W-1:0] w_wExt;
    logic [ACC_W:0]   w_sum;

    // Add with one extra bit so the carry out of the accumulator becomes
    // the sticky overflow; the beat count saturates rather than wrapping.
    always_comb begin
        w_wExt   = ACC_W'(w);
        w_sum    = {1'b0, acc} + {1'b0, w_wExt};
        acc_next = w_sum[ACC_W-1:0];
        ovf_next = ovf | w_sum[ACC_W];
        cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (load_first) begin
            acc <= w_wExt;
            cnt <= CNT_W'(1);
            ovf <= 1'b0;
        end else if (add) begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ovf_next;
        end
    end

endmodule

// File: rtl/csa_result_accum.sv
// Downstream stage of the 8-bit three-operand carry-save adder.
// Accumulates a burst of registered adder words {carry, sum} into a wider
// total and presents total, beat count and overflow on a valid/ready port.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   in_valid/in_ready           input beat handshake
//   in_sum, in_carry, in_last   adder result word and end-of-burst marker
//   out_valid/out_ready         result handshake
//   out_total, out_count, out_overflow  registered burst result
module csa_result_accum
    import csa_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [ADD_W-1:0] in_sum,
    input  logic             in_carry,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    state_t r_state;
    state_t w_nextState;

    logic [WORD_W-1:0] w_word;
    logic              w_accept;
    logic              w_clear;
    logic              w_loadFirst;
    logic              w_add;
    logic              w_loadOut;
    logic [ACC_W-1:0]  w_resTotal;
    logic [CNT_W-1:0]  w_resCount;
    logic              w_resOvf;

    logic [ACC_W-1:0]  w_acc;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_ovf;
    logic [ACC_W-1:0]  w_accNext;
    logic [CNT_W-1:0]  w_cntNext;
    logic              w_ovfNext;

    // Ready depends only on registered state so it never loops back
    // through the downstream out_ready path.
    assign w_word    = {in_carry, in_sum};
    assign in_ready  = (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign w_accept  = in_valid && in_ready;

    csa_accum_reg #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_accumReg (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .load_first (w_loadFirst),
        .add        (w_add),
        .w          (w_word),
        .acc        (w_acc),
        .cnt        (w_cnt),
        .ovf        (w_ovf),
        .acc_next   (w_accNext),
        .cnt_next   (w_cntNext),
        .ovf_next   (w_ovfNext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A single-beat burst from IDLE bypasses the accumulator entirely; the
    // last beat of a longer burst is captured from the adder's next values
    // and the accumulator is cleared at the same edge.
    always_comb begin
        w_nextState = r_state;
        w_clear     = 1'b0;
        w_loadFirst = 1'b0;
        w_add       = 1'b0;
        w_loadOut   = 1'b0;
        w_resTotal  = w_accNext;
        w_resCount  = w_cntNext;
        w_resOvf    = w_ovfNext;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_loadOut   = 1'b1;
                        w_resTotal  = ACC_W'(w_word);
                        w_resCount  = CNT_W'(1);
                        w_resOvf    = 1'b0;
                        w_nextState = HOLD;
                    end else begin
                        w_loadFirst = 1'b1;
                        w_nextState = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_loadOut   = 1'b1;
                        w_clear     = 1'b1;
                        w_nextState = HOLD;
                    end else begin
                        w_add = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_clear     = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_nextState = IDLE;
            end
        endcase
    end

    // Result registers only change on the final beat, so they hold steady
    // for as long as the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_total    <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (w_loadOut) begin
            out_total    <= w_resTotal;
            out_count    <= w_resCount;
            out_overflow <= w_resOvf;
        end
    end

    // Accumulator state is only consulted through its next-value outputs.
    logic w_unusedState;
    assign w_unusedState = ^{w_acc, w_cnt, w_ovf};

endmodule

// File: tb/tb_csa_result_accum.sv
// Self-checking bench for csa_result_accum: table-driven bursts plus
// hand-written sequences for stall, reset abort and back-pressure.
module tb_csa_result_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_sum;
    logic        in_carry;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_total;
    logic [7:0]  out_count;
    logic        out_overflow;

    int passCount;
    int checkCount;

    typedef struct {
        logic [7:0]  sum;
        logic        carry;
        int          beats;
        logic [15:0] expTotal;
        logic [7:0]  expCount;
        logic        expOvf;
    } vec_t;

    vec_t vecs[7];

    csa_result_accum #(
        .ACC_W (16),
        .CNT_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sum       (in_sum),
        .in_carry     (in_carry),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_total    (out_total),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives n beats of the same word, in_last on the final one; returns
    // #1 after the edge that accepted the last beat.
    task automatic applyStimulus(input logic [7:0] s, input logic c, input int n);
        for (int i = 0; i < n; i++) begin
            in_sum   = s;
            in_carry = c;
            in_last  = (i == n - 1);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic releaseResult(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, "_validLow"}, 32'(out_valid), 32'd0);
        checkOutput({name, "_readyBack"}, 32'(in_ready), 32'd1);
    endtask

    task automatic checkResult(input string name, input logic [15:0] t, input logic [7:0] c, input logic o);
        checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, "_inReadyLow"}, 32'(in_ready), 32'd0);
        checkOutput({name, "_total"}, 32'(out_total), 32'(t));
        checkOutput({name, "_count"}, 32'(out_count), 32'(c));
        checkOutput({name, "_ovf"}, 32'(out_overflow), 32'(o));
    endtask

    // Protocol monitor: results stable while stalled, never ready while valid.
    logic        prevHeld;
    logic [15:0] prevTotal;
    logic [7:0]  prevCount;
    logic        prevOvf;
    initial prevHeld = 1'b0;
    always @(negedge clk) begin
        if (prevHeld && !rst &&
            (out_total !== prevTotal || out_count !== prevCount || out_overflow !== prevOvf)) begin
            checkCount++;
            $display("[TB] FAIL stableWhileStalled: got 0x%0h/%0d/%0b expected 0x%0h/%0d/%0b",
                     out_total, out_count, out_overflow, prevTotal, prevCount, prevOvf);
        end
        if (out_valid === 1'b1 && in_ready !== 1'b0) begin
            checkCount++;
            $display("[TB] FAIL readyWhileValid: got in_ready=%0b expected 0", in_ready);
        end
        prevHeld  = out_valid && !out_ready && !rst;
        prevTotal = out_total;
        prevCount = out_count;
        prevOvf   = out_overflow;
    end

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sum     = 8'h00;
        in_carry   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;

        vecs[0] = '{sum: 8'hFF, carry: 1'b1, beats: 3,   expTotal: 16'h05FD, expCount: 8'd3,   expOvf: 1'b0};
        vecs[1] = '{sum: 8'h00, carry: 1'b1, beats: 1,   expTotal: 16'h0100, expCount: 8'd1,   expOvf: 1'b0};
        vecs[2] = '{sum: 8'hFF, carry: 1'b1, beats: 129, expTotal: 16'h017F, expCount: 8'd129, expOvf: 1'b1};
        vecs[3] = '{sum: 8'h01, carry: 1'b0, beats: 300, expTotal: 16'h012C, expCount: 8'd255, expOvf: 1'b0};
        vecs[4] = '{sum: 8'h80, carry: 1'b1, beats: 170, expTotal: 16'hFF00, expCount: 8'd170, expOvf: 1'b0};
        vecs[5] = '{sum: 8'h80, carry: 1'b1, beats: 171, expTotal: 16'h0080, expCount: 8'd171, expOvf: 1'b1};
        vecs[6] = '{sum: 8'h00, carry: 1'b0, beats: 2,   expTotal: 16'h0000, expCount: 8'd2,   expOvf: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_outValid", 32'(out_valid), 32'd0);
        checkOutput("reset_inReady", 32'(in_ready), 32'd1);
        checkOutput("reset_total", 32'(out_total), 32'd0);
        checkOutput("reset_count", 32'(out_count), 32'd0);
        checkOutput("reset_ovf", 32'(out_overflow), 32'd0);

        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("v%0d_readyBefore", k), 32'(in_ready), 32'd1);
            applyStimulus(vecs[k].sum, vecs[k].carry, vecs[k].beats);
            checkResult($sformatf("v%0d", k), vecs[k].expTotal, vecs[k].expCount, vecs[k].expOvf);
            releaseResult($sformatf("v%0d", k));
        end

        // Stall: result pending while upstream keeps offering w=7 beats.
        applyStimulus(8'h03, 1'b0, 1);
        in_sum   = 8'h07;
        in_carry = 1'b0;
        in_last  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkResult($sformatf("stall%0d", i), 16'h0003, 8'd1, 1'b0);
        end
        in_valid = 1'b0;
        releaseResult("stallRelease");
        applyStimulus(8'h07, 1'b0, 2);
        checkResult("afterStall", 16'h000E, 8'd2, 1'b0);
        releaseResult("afterStall");

        // Reset mid-burst discards the partial total.
        in_sum   = 8'h09;
        in_carry = 1'b0;
        in_last  = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("midReset_outValid", 32'(out_valid), 32'd0);
        checkOutput("midReset_inReady", 32'(in_ready), 32'd1);
        applyStimulus(8'h05, 1'b0, 1);
        checkResult("postAbort", 16'h0005, 8'd1, 1'b0);

        // Reset while a result is pending drops it without a handshake.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("holdReset_outValid", 32'(out_valid), 32'd0);
        checkOutput("holdReset_inReady", 32'(in_ready), 32'd1);
        applyStimulus(8'hFF, 1'b0, 2);
        checkResult("postHoldReset", 16'h01FE, 8'd2, 1'b0);
        releaseResult("postHoldReset");

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
